// File: rtl/divisor_iterativo.sv
// divisor_iterativo
//   Multi-cycle restoring divider that produces one quotient bit per clock.
//   It serves DIV (signed) and DIVU (unsigned). The quotient goes to LO and
//   the remainder goes to HI. Control stalls the PC while busy is high.
//
//   State table
//     state  | meaning
//     IDLE   | waiting for start, busy=0
//     RUN    | shift-subtract steps, one quotient bit per edge, busy=1
//     FIX    | sign correction / divide-by-zero result written, busy=1
//     DONE   | results valid, done=1 for one cycle, start may be accepted
//
//   Ports
//     clk          rising-edge clock
//     reset_n      asynchronous active-low reset
//     start        request, sampled only while busy=0
//     signed_op    1 = DIV (two's complement), 0 = DIVU
//     dividend     numerator, sampled at the accepting edge
//     divisor      denominator, sampled at the accepting edge
//     busy         operation in progress
//     done         one-cycle pulse, results valid
//     quotient     result quotient, held until the next FIX
//     remainder    result remainder, held until the next FIX
//     div_by_zero  last accepted op had divisor == 0
module divisor_iterativo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;

  // Magnitudes wrap for the most-negative value. This wrap is what gives
  // MIN / -1 = MIN with a zero remainder.
  assign w_dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The partial remainder is always below the divisor. After the shift it
  // fits in WIDTH+1 bits, and the difference fits in WIDTH+1 signed bits.
  assign w_rsh   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_rsh - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: w_accept = start;
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_STEP) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        w_next   = S_IDLE;
        w_accept = start;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_accept) w_next = (divisor == '0) ? S_FIX : S_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_quo         <= '0;
      r_rem         <= '0;
      r_dvs         <= '0;
      r_dvd_raw     <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_quo     <= w_dvd_mag;
      r_rem     <= '0;
      r_dvs     <= w_dvs_mag;
      r_dvd_raw <= dividend;
      r_neg_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_r   <= signed_op & dividend[WIDTH-1];
      r_dz      <= (divisor == '0);
    end else if (r_state == S_RUN) begin
      r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_rsh[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_FIX) begin
      r_div_by_zero <= r_dz;
      if (r_dz) begin
        r_quotient  <= '1;
        r_remainder <= r_dvd_raw;
      end else begin
        r_quotient  <= r_neg_q ? -r_quo : r_quo;
        r_remainder <= r_neg_r ? -r_rem : r_rem;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_divisor_iterativo.sv
module tb_divisor_iterativo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_vec = 0;
  int n_bad = 0;

  divisor_iterativo #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. 64-bit signed math truncates toward
  // zero, and its remainder takes the dividend's sign.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  // The caller must be just past a negedge. The task returns at the negedge
  // where done is seen, or when the cycle budget runs out.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inject_at, output int lat, output bit busy_ok);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (lat <= 200) begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int lat, input bit busy_ok);
    logic [31:0] eq, er;
    logic        edz;
    model(a, b, s, eq, er, edz);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    chk({tag, "_lat"}, lat, (b == 0) ? 32'd1 : 32'd33);
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int          lat;
    bit          bok;
    bit          seen;
    logic [31:0] a, b, hq, hr;
    logic        s;

    vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0};
    vecs[3] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1};
    vecs[4] = '{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
    vecs[8] = '{32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0};

    reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", 32'(div_by_zero), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Each op is issued at the done negedge of the previous one, so every
    // entry after the first is accepted from DONE (back-to-back).
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, -1, lat, bok);
      chk($sformatf("vec%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].dz));
      chk($sformatf("vec%0d_lat", i), lat, (vecs[i].b == 0) ? 32'd1 : 32'd33);
      chk($sformatf("vec%0d_busy", i), 32'(bok), 1);
    end

    // done is a single-cycle pulse, and results hold afterwards.
    hq = quotient; hr = remainder;
    @(negedge clk);
    chk("pulse_done", 32'(done), 0);
    chk("pulse_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("hold_q", quotient, hq);
    chk("hold_r", remainder, hr);

    // A start pulsed mid-operation is ignored.
    run_op(32'd100, 32'd7, 1'b0, 10, lat, bok);
    check_op("ignore", 32'd100, 32'd7, 1'b0, lat, bok);
    @(negedge clk);
    chk("ignore_idle", 32'(busy), 0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 0 && a == 32'h8000_0000) b = 32'd3;
      run_op(a, b, s, -1, lat, bok);
      check_op($sformatf("rnd%0d", i), a, b, s, lat, bok);
    end

    // Reset mid-operation aborts immediately, and no done pulse follows.
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_q", quotient, 0);
    chk("abort_dz", 32'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 0);

    run_op(32'd1000, 32'd3, 1'b0, -1, lat, bok);
    check_op("recover", 32'd1000, 32'd3, 1'b0, lat, bok);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
